timed_event_gen: RTL and testbench

- Synthesizable, cycle-counted scheduler for delayed level changes on two outputs, x_out and y_out.
- Replaces time-unit delayed assignments with counters: a start command loads a per-channel delay and target value, and each output takes its value when its count expires.
- Sits directly upstream of the output-observing test logic and feeds it deterministic, cycle-exact transitions.

---
 rtl/timed_event_gen.sv | 131 +++++++++++++
 tb/tb_timed_event_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/timed_event_gen.sv
// Cycle-counted scheduler: a start command loads per-channel delays and target
// values, and each output takes its value when its counter expires.
module timed_event_gen #(
   parameter int   CNT_W  = 16,
   parameter logic INIT_X = 1'b1,
   parameter logic INIT_Y = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] delay_x,
   input  logic [CNT_W-1:0] delay_y,
   input  logic             val_x,
   input  logic             val_y,
   input  logic             abort,
   input  logic             clr_err,
   output logic             x_out,
   output logic             y_out,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [1:0] INIT_VEC = {INIT_Y, INIT_X};

   state_t           state_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             overrun_reg;
   logic             accept;
   logic             abort_run;
   logic             any_delay;
   logic [1:0]       last_vec;
   logic [1:0]       out_vec;
   logic [1:0]       val_vec;
   logic [CNT_W-1:0] delay_arr [2];

   assign accept    = start && (state_reg == IDLE);
   assign abort_run = abort && (state_reg == RUN);
   assign any_delay = (delay_x != '0) || (delay_y != '0);

   assign delay_arr[0] = delay_x;
   assign delay_arr[1] = delay_y;
   assign val_vec      = {val_y, val_x};

   // Channel 0 drives x_out, channel 1 drives y_out.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic [CNT_W-1:0] cnt_reg;
         logic             val_reg;
         logic             out_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg <= '0;
               val_reg <= INIT_VEC[gi];
               out_reg <= INIT_VEC[gi];
            end else if (accept) begin
               cnt_reg <= delay_arr[gi];
               val_reg <= val_vec[gi];
               if (delay_arr[gi] == '0)
                  out_reg <= val_vec[gi];
            end else if (abort_run) begin
               // Abort wins over a firing on the same edge.
               cnt_reg <= '0;
            end else if ((state_reg == RUN) && (cnt_reg != '0)) begin
               cnt_reg <= cnt_reg - CNT_W'(1);
               if (cnt_reg == CNT_W'(1))
                  out_reg <= val_reg;
            end
         end

         // Channel fires (or already has) by the end of this RUN cycle.
         assign last_vec[gi] = (cnt_reg <= CNT_W'(1));
         assign out_vec[gi]  = out_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (any_delay) begin
                     state_reg <= RUN;
                     busy_reg  <= 1'b1;
                  end else begin
                     done_reg <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (&last_vec) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase

         // A new overrun beats a simultaneous clear.
         if (start && busy_reg)
            overrun_reg <= 1'b1;
         else if (clr_err)
            overrun_reg <= 1'b0;
      end
   end

   assign x_out   = out_vec[0];
   assign y_out   = out_vec[1];
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign overrun = overrun_reg;

endmodule

// File: tb/tb_timed_event_gen.sv
// Directed, table-driven bench for timed_event_gen with hand-written
// sequences for long delays, abort and mid-run reset.
module tb_timed_event_gen;

   localparam int CNT_W = 16;

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b0;
   logic             start   = 1'b0;
   logic [CNT_W-1:0] delay_x = '0;
   logic [CNT_W-1:0] delay_y = '0;
   logic             val_x   = 1'b0;
   logic             val_y   = 1'b0;
   logic             abort   = 1'b0;
   logic             clr_err = 1'b0;
   logic             x_out;
   logic             y_out;
   logic             busy;
   logic             done;
   logic             overrun;

   int errors = 0;
   int checks = 0;

   timed_event_gen #(
      .CNT_W  (CNT_W),
      .INIT_X (1'b1),
      .INIT_Y (1'b0)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .delay_x (delay_x),
      .delay_y (delay_y),
      .val_x   (val_x),
      .val_y   (val_y),
      .abort   (abort),
      .clr_err (clr_err),
      .x_out   (x_out),
      .y_out   (y_out),
      .busy    (busy),
      .done    (done),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic st;
      int   dx;
      int   dy;
      logic vx;
      logic vy;
      logic ab;
      logic clr;
      logic ex;
      logic ey;
      logic eb;
      logic ed;
      logic eo;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic st, input int dx, input int dy,
                               input logic vx, input logic vy, input logic ab,
                               input logic clr, input logic ex, input logic ey,
                               input logic eb, input logic ed, input logic eo);
      vec_t v;
      v.st = st; v.dx = dx; v.dy = dy; v.vx = vx; v.vy = vy; v.ab = ab;
      v.clr = clr; v.ex = ex; v.ey = ey; v.eb = eb; v.ed = ed; v.eo = eo;
      return v;
   endfunction

   task automatic drive(input logic st, input int dx, input int dy,
                        input logic vx, input logic vy, input logic ab,
                        input logic clr);
      start   = st;
      delay_x = CNT_W'(dx);
      delay_y = CNT_W'(dy);
      val_x   = vx;
      val_y   = vy;
      abort   = ab;
      clr_err = clr;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ex, input logic ey,
                          input logic eb, input logic ed, input logic eo);
      chk($sformatf("%s x_out", tag), x_out, ex);
      chk($sformatf("%s y_out", tag), y_out, ey);
      chk($sformatf("%s busy", tag), busy, eb);
      chk($sformatf("%s done", tag), done, ed);
      chk($sformatf("%s overrun", tag), overrun, eo);
   endtask

   initial begin
      //           st dx dy vx vy ab clr  ex ey eb ed eo
      // both delays zero, then abort while idle
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0));
      // equal delays fire together; start right after done is accepted
      vecs.push_back(mk(1, 3, 3, 0, 1, 0, 0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 2, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
      // dx=8, second start at T+4 sets overrun, clr_err later clears it
      vecs.push_back(mk(1, 8, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0,  1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
      // start on the done edge is an overrun; next-cycle start is accepted
      vecs.push_back(mk(1, 2, 1, 1, 1, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1,  1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
      // set wins over simultaneous clear
      vecs.push_back(mk(1, 2, 2, 1, 1, 0, 0,  0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0));

      // reset values
      repeat (3) tick;
      chk_all("reset", 1, 0, 0, 0, 0);
      rst_n = 1'b1;
      $display("reset: x=%b y=%b busy=%b done=%b ovr=%b", x_out, y_out, busy, done, overrun);

      // long schedule: y at T+500, x at T+1000
      drive(1, 1000, 500, 0, 1, 0, 0);
      tick;
      chk_all("long T", 1, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 1001; k++) begin
         tick;
         chk_all($sformatf("long T+%0d", k), (k >= 1000) ? 1'b0 : 1'b1,
                 (k >= 500) ? 1'b1 : 1'b0, (k < 1000) ? 1'b1 : 1'b0,
                 (k == 1000) ? 1'b1 : 1'b0, 1'b0);
      end
      $display("long: dx=1000 dy=500 -> x=%b y=%b busy=%b", x_out, y_out, busy);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].st, vecs[i].dx, vecs[i].dy, vecs[i].vx, vecs[i].vy,
               vecs[i].ab, vecs[i].clr);
         tick;
         chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].eb,
                 vecs[i].ed, vecs[i].eo);
         $display("vec %0d: start=%b dx=%0d dy=%0d abort=%b clr=%b -> x=%b y=%b busy=%b done=%b ovr=%b",
                  i, vecs[i].st, vecs[i].dx, vecs[i].dy, vecs[i].ab, vecs[i].clr,
                  x_out, y_out, busy, done, overrun);
      end
      drive(0, 0, 0, 0, 0, 0, 0);

      // abort at edge T+16 of a dx=10/dy=20 schedule
      drive(1, 10, 20, 0, 0, 0, 0);
      tick;
      chk_all("abort T", 1, 1, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 25; k++) begin
         abort = (k == 16);
         tick;
         abort = 1'b0;
         chk_all($sformatf("abort T+%0d", k), (k >= 10) ? 1'b0 : 1'b1, 1'b1,
                 (k < 16) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      end
      $display("abort: dx=10 dy=20 -> x=%b y=%b busy=%b", x_out, y_out, busy);

      // abort on the firing edge cancels that firing
      drive(1, 4, 6, 1, 0, 0, 0);
      tick;
      chk_all("abfire T", 0, 1, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         abort = (k == 4);
         tick;
         abort = 1'b0;
         chk_all($sformatf("abfire T+%0d", k), 1'b0, 1'b1,
                 (k < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      end
      $display("abort-on-fire: dx=4 dy=6 -> x=%b y=%b busy=%b", x_out, y_out, busy);

      // asynchronous reset in the middle of a dx=10 schedule
      drive(1, 10, 0, 1, 1, 0, 0);
      tick;
      chk_all("rst T", 0, 1, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         tick;
         chk_all($sformatf("rst T+%0d", k), 0, 1, 1, 0, 0);
      end
      #2 rst_n = 1'b0;
      #1 chk_all("rst async", 1, 0, 0, 0, 0);
      #1 rst_n = 1'b1;
      for (int k = 6; k <= 12; k++) begin
         tick;
         chk_all($sformatf("rst T+%0d", k), 1, 0, 0, 0, 0);
      end
      $display("mid-run reset: x=%b y=%b busy=%b", x_out, y_out, busy);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
